// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared constants, strobe-width helper and response record for mem_port_arbiter
package mem_arb_pkg;
    localparam int ARB_RR    = 0;
    localparam int ARB_FIXED = 1;
    localparam int MAX_CH    = 32;
    function automatic int strb_width(input int dw);
        return dw / 8;
    endfunction
    typedef struct packed {
        logic [MAX_CH-1:0] ch;
        logic              err;
        logic              is_read;
    } rsp_rec_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot grant by round-robin or fixed priority; owns the rotating pointer
module rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_CH   = 2,
    parameter int ARB_MODE = ARB_RR
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NUM_CH-1:0] req,
    output logic [NUM_CH-1:0] gnt
);
    localparam int PW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
    logic [PW-1:0] ptr, ptr_nxt;
    logic          found;
    int            base, c;
    always_comb begin
        gnt     = '0;
        ptr_nxt = ptr;
        found   = 1'b0;
        c       = 0;
        base    = (ARB_MODE == ARB_FIXED) ? 0 : int'(ptr);
        for (int i = 0; i < NUM_CH; i++) begin
            c = (base + i) % NUM_CH;
            if (!found && req[c]) begin
                found   = 1'b1;
                gnt[c]  = 1'b1;
                ptr_nxt = PW'((c + 1) % NUM_CH);
            end
        end
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) ptr <= '0;
        else ptr <= ptr_nxt;
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one byte-strobed RAM port among NUM_CH requesters with a registered response
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_CH     = 2,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 2 ** ADDR_WIDTH,
    parameter int ARB_MODE   = ARB_RR
) (
    input  logic                                     clk,
    input  logic                                     reset_n,
    input  logic [NUM_CH-1:0]                        req_valid,
    output logic [NUM_CH-1:0]                        req_ready,
    input  logic [NUM_CH-1:0]                        req_wr_en,
    input  logic [NUM_CH*strb_width(DATA_WIDTH)-1:0] req_wr_strobe,
    input  logic [NUM_CH*ADDR_WIDTH-1:0]             req_addr,
    input  logic [NUM_CH*DATA_WIDTH-1:0]             req_wdata,
    output logic [NUM_CH-1:0]                        rsp_valid,
    output logic [NUM_CH-1:0]                        rsp_err,
    output logic [DATA_WIDTH-1:0]                    rsp_rdata,
    output logic                                     mem_en,
    output logic                                     mem_wr_en,
    output logic [strb_width(DATA_WIDTH)-1:0]        mem_wr_strobe,
    output logic [ADDR_WIDTH-1:0]                    mem_addr,
    output logic [DATA_WIDTH-1:0]                    mem_wdata,
    input  logic [DATA_WIDTH-1:0]                    mem_rdata
);
    localparam int SW = strb_width(DATA_WIDTH);
    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);
    logic [NUM_CH-1:0]     gnt;
    logic                  any_gnt, req_err, sel_wr;
    logic [SW-1:0]         sel_strb;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    rsp_rec_t              rec;
    logic                  unused_ch;
    rr_arbiter #(.NUM_CH(NUM_CH), .ARB_MODE(ARB_MODE)) u_arb (
        .clk(clk), .reset_n(reset_n), .req(req_valid), .gnt(gnt)
    );
    assign req_ready = gnt;
    assign any_gnt   = |gnt;
    always_comb begin
        sel_wr    = 1'b0;
        sel_strb  = '0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (gnt[i]) begin
                sel_wr    = req_wr_en[i];
                sel_strb  = req_wr_strobe[i*SW +: SW];
                sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end
    // Erroring requests are still accepted but kept off the RAM
    assign req_err       = any_gnt && ({1'b0, sel_addr} >= DEPTH_L || (sel_wr && sel_strb == '0));
    assign mem_en        = any_gnt && !req_err;
    assign mem_wr_en     = mem_en && sel_wr;
    assign mem_wr_strobe = mem_wr_en ? sel_strb : '0;
    assign mem_addr      = mem_en ? sel_addr : '0;
    assign mem_wdata     = mem_en ? sel_wdata : '0;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rec <= '0;
        else rec <= '{ch: MAX_CH'(gnt), err: req_err, is_read: any_gnt && !sel_wr};
    end
    assign rsp_valid = rec.ch[NUM_CH-1:0];
    assign rsp_err   = rsp_valid & {NUM_CH{rec.err}};
    assign rsp_rdata = (|rsp_valid && rec.is_read && !rec.err) ? mem_rdata : '0;
    assign unused_ch = ^rec.ch;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed table, corner sequences and randomized model check of mem_port_arbiter
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  req_valid, req_wr_en, req_ready, rsp_valid, rsp_err;
    logic [7:0]  req_wr_strobe;
    logic [15:0] req_addr;
    logic [63:0] req_wdata;
    logic [31:0] rsp_rdata, mem_wdata, mem_rdata;
    logic        mem_en, mem_wr_en;
    logic [3:0]  mem_wr_strobe;
    logic [7:0]  mem_addr;
    logic [1:0]  rdy_f, rv_f, re_f;
    logic [31:0] rd_f, mwd_f, mrd_f;
    logic        me_f, mwe_f;
    logic [3:0]  mws_f;
    logic [7:0]  ma_f;
    logic [31:0] ram0 [256];
    logic [31:0] ram1 [256];
    logic [31:0] gold [256];
    int          n_vec = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.NUM_CH(2), .ADDR_WIDTH(8), .DATA_WIDTH(32), .DEPTH(200), .ARB_MODE(0)) dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_wr_en(req_wr_en), .req_wr_strobe(req_wr_strobe), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
        .mem_en(mem_en), .mem_wr_en(mem_wr_en), .mem_wr_strobe(mem_wr_strobe),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );
    mem_port_arbiter #(.NUM_CH(2), .ADDR_WIDTH(8), .DATA_WIDTH(32), .DEPTH(200), .ARB_MODE(1)) dut_fx (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(rdy_f),
        .req_wr_en(req_wr_en), .req_wr_strobe(req_wr_strobe), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rv_f), .rsp_err(re_f), .rsp_rdata(rd_f),
        .mem_en(me_f), .mem_wr_en(mwe_f), .mem_wr_strobe(mws_f),
        .mem_addr(ma_f), .mem_wdata(mwd_f), .mem_rdata(mrd_f)
    );

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_wr_en) begin
                for (int b = 0; b < 4; b++)
                    if (mem_wr_strobe[b]) ram0[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end else mem_rdata <= ram0[mem_addr];
        end
    end
    always @(posedge clk) begin
        if (me_f) begin
            if (mwe_f) begin
                for (int b = 0; b < 4; b++)
                    if (mws_f[b]) ram1[ma_f][8*b +: 8] <= mwd_f[8*b +: 8];
            end else mrd_f <= ram1[ma_f];
        end
    end

    typedef struct {
        logic [1:0]  v, w;
        logic [7:0]  s;
        logic [15:0] a;
        logic [63:0] d;
        logic [1:0]  rdy;
        logic        en;
        logic [1:0]  rv, re;
        logic [31:0] rd;
    } vec_t;
    vec_t tbl [13];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] v, input logic [1:0] w, input logic [7:0] s,
                         input logic [15:0] a, input logic [63:0] d);
        @(posedge clk);
        #1;
        req_valid = v;
        req_wr_en = w;
        req_wr_strobe = s;
        req_addr = a;
        req_wdata = d;
        #3;
    endtask

    initial begin
        int          ptr, k, kk, kf;
        logic [1:0]  v, w, erv, ere, erv_f, xr, xf;
        logic [7:0]  s, ak;
        logic [15:0] a;
        logic [63:0] d;
        logic [3:0]  sk;
        logic [31:0] dk, erd;
        logic        wk, e, en;
        tbl[0]  = '{2'b10, 2'b10, 8'hF0, 16'h0500, 64'hDEADBEEF_00000000, 2'b10, 1'b1, 2'b00, 2'b00, 32'h0};
        tbl[1]  = '{2'b10, 2'b00, 8'h00, 16'h0500, 64'h0,                 2'b10, 1'b1, 2'b10, 2'b00, 32'h0};
        tbl[2]  = '{2'b00, 2'b00, 8'h00, 16'h0000, 64'h0,                 2'b00, 1'b0, 2'b10, 2'b00, 32'hDEADBEEF};
        tbl[3]  = '{2'b01, 2'b01, 8'h0F, 16'h0010, 64'h00000000_FFFFFFFF, 2'b01, 1'b1, 2'b00, 2'b00, 32'h0};
        tbl[4]  = '{2'b01, 2'b01, 8'h05, 16'h0010, 64'h00000000_11223344, 2'b01, 1'b1, 2'b01, 2'b00, 32'h0};
        tbl[5]  = '{2'b10, 2'b00, 8'h00, 16'h1000, 64'h0,                 2'b10, 1'b1, 2'b01, 2'b00, 32'h0};
        tbl[6]  = '{2'b01, 2'b00, 8'h00, 16'h00F0, 64'h0,                 2'b01, 1'b0, 2'b10, 2'b00, 32'hFF22FF44};
        tbl[7]  = '{2'b10, 2'b10, 8'h00, 16'h1000, 64'h12345678_00000000, 2'b10, 1'b0, 2'b01, 2'b01, 32'h0};
        tbl[8]  = '{2'b01, 2'b00, 8'h00, 16'h0010, 64'h0,                 2'b01, 1'b1, 2'b10, 2'b10, 32'h0};
        tbl[9]  = '{2'b00, 2'b00, 8'h00, 16'h0000, 64'h0,                 2'b00, 1'b0, 2'b01, 2'b00, 32'hFF22FF44};
        tbl[10] = '{2'b11, 2'b00, 8'h00, 16'h0510, 64'h0,                 2'b10, 1'b1, 2'b00, 2'b00, 32'h0};
        tbl[11] = '{2'b11, 2'b00, 8'h00, 16'h0510, 64'h0,                 2'b01, 1'b1, 2'b10, 2'b00, 32'hDEADBEEF};
        tbl[12] = '{2'b00, 2'b00, 8'h00, 16'h0000, 64'h0,                 2'b00, 1'b0, 2'b01, 2'b00, 32'hFF22FF44};
        reset_n = 1'b0;
        req_valid = '0; req_wr_en = '0; req_wr_strobe = '0; req_addr = '0; req_wdata = '0;
        repeat (2) @(posedge clk);
        #4;
        chk("rst_rsp_valid", rsp_valid, 2'b00);
        chk("rst_rsp_err", rsp_err, 2'b00);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_ready", req_ready, 2'b00);
        chk("rst_mem_en", mem_en, 1'b0);
        reset_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].v, tbl[i].w, tbl[i].s, tbl[i].a, tbl[i].d);
            chk($sformatf("tbl%0d_ready", i), req_ready, tbl[i].rdy);
            chk($sformatf("tbl%0d_mem_en", i), mem_en, tbl[i].en);
            chk($sformatf("tbl%0d_rsp_valid", i), rsp_valid, tbl[i].rv);
            chk($sformatf("tbl%0d_rsp_err", i), rsp_err, tbl[i].re);
            chk($sformatf("tbl%0d_rsp_rdata", i), rsp_rdata, tbl[i].rd);
        end

        reset_n = 1'b0;
        drive(2'b00, 2'b00, 8'h00, 16'h0, 64'h0);
        reset_n = 1'b1;
        xr = 2'b00;
        for (int i = 0; i < 6; i++) begin
            drive(2'b11, 2'b00, 8'h00, 16'h0510, 64'h0);
            chk($sformatf("rr%0d_ready", i), req_ready, (i % 2 == 0) ? 2'b01 : 2'b10);
            chk($sformatf("rr%0d_rsp_valid", i), rsp_valid, xr);
            chk($sformatf("fx%0d_ready", i), rdy_f, 2'b01);
            chk($sformatf("fx%0d_rsp_valid", i), rv_f, (i == 0) ? 2'b00 : 2'b01);
            xr = (i % 2 == 0) ? 2'b01 : 2'b10;
        end
        drive(2'b10, 2'b00, 8'h00, 16'h0510, 64'h0);
        chk("fx_ch1_ready", rdy_f, 2'b10);
        chk("fx_ch1_rsp_valid", rv_f, 2'b01);
        chk("rr_tail_rsp_valid", rsp_valid, 2'b10);

        drive(2'b01, 2'b00, 8'h00, 16'h0005, 64'h0);
        drive(2'b01, 2'b00, 8'h00, 16'h0005, 64'h0);
        chk("mid_ready", req_ready, 2'b01);
        reset_n = 1'b0;
        drive(2'b00, 2'b00, 8'h00, 16'h0, 64'h0);
        chk("mid_rst_rsp_valid", rsp_valid, 2'b00);
        chk("mid_rst_rsp_rdata", rsp_rdata, 32'h0);
        reset_n = 1'b1;
        drive(2'b00, 2'b00, 8'h00, 16'h0, 64'h0);
        chk("post_rst_rsp_valid", rsp_valid, 2'b00);
        drive(2'b11, 2'b00, 8'h00, 16'h0510, 64'h0);
        chk("post_rst_ready", req_ready, 2'b01);

        reset_n = 1'b0;
        drive(2'b00, 2'b00, 8'h00, 16'h0, 64'h0);
        reset_n = 1'b1;
        for (int i = 0; i < 256; i++) gold[i] = ram0[i];
        ptr = 0; erv = '0; ere = '0; erd = '0; erv_f = '0;
        for (int c = 0; c < 300; c++) begin
            v = 2'($urandom); w = 2'($urandom); s = 8'($urandom);
            if ($urandom_range(0, 4) == 0) s[3:0] = 4'h0;
            if ($urandom_range(0, 4) == 0) s[7:4] = 4'h0;
            a = 16'($urandom); d = {$urandom, $urandom};
            drive(v, w, s, a, d);
            chk("rnd_rsp_valid", rsp_valid, erv);
            chk("rnd_rsp_err", rsp_err, ere);
            chk("rnd_rsp_rdata", rsp_rdata, erd);
            chk("rnd_fx_rsp_valid", rv_f, erv_f);
            k = -1;
            for (int i = 0; i < 2; i++) if (k < 0 && v[(ptr + i) % 2]) k = (ptr + i) % 2;
            kk = (k < 0) ? 0 : k;
            ak = a[8*kk +: 8]; sk = s[4*kk +: 4]; wk = w[kk]; dk = d[32*kk +: 32];
            xr = (k < 0) ? 2'b00 : 2'(1 << k);
            e = (k >= 0) && (ak >= 8'd200 || (wk && sk == 4'h0));
            en = (k >= 0) && !e;
            chk("rnd_ready", req_ready, xr);
            chk("rnd_mem_en", mem_en, en);
            chk("rnd_mem_wr_en", mem_wr_en, en && wk);
            if (en) begin
                chk("rnd_mem_addr", mem_addr, ak);
                chk("rnd_mem_strobe", mem_wr_strobe, wk ? sk : 4'h0);
                chk("rnd_mem_wdata", mem_wdata, dk);
            end
            kf = v[0] ? 0 : (v[1] ? 1 : -1);
            xf = (kf < 0) ? 2'b00 : 2'(1 << kf);
            chk("rnd_fx_ready", rdy_f, xf);
            erv = xr;
            ere = e ? xr : 2'b00;
            erd = (en && !wk) ? gold[ak] : 32'h0;
            erv_f = xf;
            if (en && wk)
                for (int b = 0; b < 4; b++) if (sk[b]) gold[ak][8*b +: 8] = dk[8*b +: 8];
            if (k >= 0) ptr = (k + 1) % 2;
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
